control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Moore FSM that generates the datapath control strobes for fetch (T0-T2) and
//  execute (T3-T6) of ALU-class instructions, replacing hand-sequenced bench strobes.
//  Sits beside the datapath: reads IR, drives PC/MAR/MDR/Y/Z/HI/LO strobes,
//  select-and-encode register controls (Gra/Grb/Grc/Rin/Rout) and the ALU opcode.
// PARAMETERS
//  OPW      5   opcode width, IR[31:31-OPW+1]
//  HALT_OP  5'b11011  opcode that stops the sequencer
// PORTS
//  Clock      in   1   system clock, rising edge
//  clear      in   1   async active-low reset (0 = reset)
//  Start      in   1   launch fetch from IDLE (sampled on clock)
//  Mem_ready  in   1   memory read data valid on Mdatain this cycle
//  IR         in   32  instruction register contents
//  PCout,Zlowout,Zhighout,MDRout  out 1  bus-driver enables
//  MARin,PCin,MDRin,IRin,Yin,Zin,HIin,LOin  out 1  register load enables
//  IncPC,Read out  1   PC increment in ALU, memory read
//  Gra,Grb,Grc,Rin,Rout  out 1  register-field select / GPR load / GPR drive
//  alu_op     out  5   ALU operation (= IR opcode while alu_en=1, else 0)
//  alu_en     out  1   ALU operation strobe
//  Run        out  1   1 in every state except IDLE and HALT
//  Done       out  1   1-cycle pulse in final execute state of each instruction
//  Illegal    out  1   sticky: unsupported opcode decoded
// BEHAVIOUR
//  - States: IDLE,T0,T1,T1W,T2,T3,T4,T5,T6,HALT. Reset -> IDLE; all outputs 0,
//    Illegal 0. clear deasserted mid-instruction aborts immediately to IDLE.
//  - Outputs are pure functions of registered state + IR; no glitch paths from Start.
//  - IDLE: Start=1 -> T0. T0: PCout,MARin,IncPC,Zin -> T1.
//  - T1: Zlowout,PCin,Read, MDRin=Mem_ready; Mem_ready ? T2 : T1W. PCin exactly 1 cycle.
//  - T1W: Read=1, MDRin=Mem_ready; hold until Mem_ready=1 -> T2. No wait bound.
//  - T2: MDRout,IRin -> T3. IR is valid from T3 onward.
//  - Opcode classes (IR[31:27]): 3-op add 00011,sub 00100,and 00101,or 00110,
//    ror 00111,rol 01000,shr 01001,shra 01010,shl 01011; 2-op mul 01111,div 10000;
//    unary neg 10001,not 10010; HALT_OP; all others illegal.
//  - 3-op: T3 Grb,Rout,Yin; T4 Grc,Rout,alu_en,Zin; T5 Zlowout,Gra,Rin,Done.
//  - mul/div: T3 Gra,Rout,Yin; T4 Grb,Rout,alu_en,Zin; T5 Zlowout,LOin;
//    T6 Zhighout,HIin,Done.
//  - unary: T3 Grb,Rout,alu_en,Zin; T4 Zlowout,Gra,Rin,Done.
//  - Done state -> T0 (free-running). Instruction latency: 6/7/5 cycles + wait cycles.
//  - HALT_OP at T3 -> HALT with Done=1 in that T3 cycle; illegal at T3 -> HALT, Illegal=1.
//  - HALT exits only via clear. Start ignored outside IDLE.
//  - At most one bus driver (PCout,Zlowout,Zhighout,MDRout,Rout) high in any cycle.
// CONFIGURATION
//  SINGLE_STEP_EN defined: Done state -> IDLE instead of T0; each Start pulse runs
//    exactly one instruction. Undefined: Done state -> T0, Start only leaves reset IDLE.
// TESTING
//  1 clear=0 while in T4 -> all outputs 0 async, state IDLE; Run=0 same cycle.
//  2 Start, Mem_ready=1, IR=32'h28918000 (and R1,R2,R3) -> T0..T5 strobes as above,
//    alu_op=5'b00101 only in T4, Done in cycle 6, next cycle T0.
//  3 Mem_ready low 3 cycles in fetch -> T1W x3, Read held 4 cycles, PCin 1 cycle,
//    MDRin only with Mem_ready, IRin 1 cycle later.
//  4 IR opcode 01111 (mul) -> LOin in T5, HIin in T6, Done in T6; opcode 10010 (not)
//    -> Done in T4, Yin never asserted.
//  5 IR opcode 11111 -> HALT, Illegal=1, Run=0; Start ignored; clear clears Illegal.
//  6 SINGLE_STEP_EN: two instructions need two Start pulses; Run=0 between them.
//  All: assert one-hot bus drivers and alu_op=0 whenever alu_en=0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM producing the datapath control strobes for the
// fetch (T0-T2) and execute (T3-T6) phases of ALU-class instructions.
// Optional feature macro: SINGLE_STEP_EN. When it is defined, each Start pulse
// runs exactly one instruction and the sequencer returns to IDLE afterwards.
// When it is undefined, the sequencer runs instructions back to back.
//
// Memory handshake: Mem_ready is a one-sided "data valid" strobe. During T1
// and T1W, Read is held high. The fetch completes in the cycle where
// Mem_ready=1 is seen; MDRin follows Mem_ready directly in that cycle. There is
// no ready/back-pressure towards memory and no bound on the wait.
module control_sequencer #(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] HALT_OP = 5'b11011
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Start,
  input  logic        Mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  alu_op,
  output logic        alu_en,
  output logic        Run,
  output logic        Done,
  output logic        Illegal,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_HALT = 4'd9
  } state_t;

`ifdef SINGLE_STEP_EN
  localparam state_t DONE_NEXT = S_IDLE;
`else
  localparam state_t DONE_NEXT = S_T0;
`endif

  state_t         state;
  state_t         next_state;
  logic           illegal_q;
  logic [OPW-1:0] opcode;
  logic           is_3op;
  logic           is_2op;
  logic           is_unary;
  logic           is_halt;
  logic           unused_ir;

  assign opcode    = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];

  // Decode the instruction class from the opcode field.
  always_comb begin
    is_3op   = 1'b0;
    is_2op   = 1'b0;
    is_unary = 1'b0;
    is_halt  = (opcode == HALT_OP);
    case (opcode)
      OPW'(5'b00011), OPW'(5'b00100), OPW'(5'b00101), OPW'(5'b00110),
      OPW'(5'b00111), OPW'(5'b01000), OPW'(5'b01001), OPW'(5'b01010),
      OPW'(5'b01011): is_3op   = 1'b1;
      OPW'(5'b01111), OPW'(5'b10000): is_2op = 1'b1;
      OPW'(5'b10001), OPW'(5'b10010): is_unary = 1'b1;
      default: ;
    endcase
  end

  // State register and sticky illegal-opcode flag; clear aborts at once.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_T3 && !(is_3op || is_2op || is_unary || is_halt))
        illegal_q <= 1'b1;
    end
  end

  // Next-state and Moore strobes from the registered state (plus IR/Mem_ready).
  always_comb begin
    next_state = state;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    alu_en     = 1'b0;
    Done       = 1'b0;
    Run        = (state != S_IDLE) && (state != S_HALT);
    case (state)
      S_IDLE: if (Start) next_state = S_T0;
      S_T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        Zlowout    = 1'b1;
        PCin       = 1'b1;
        Read       = 1'b1;
        MDRin      = Mem_ready;
        next_state = Mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = Mem_ready;
        if (Mem_ready) next_state = S_T2;
      end
      S_T2: begin
        MDRout     = 1'b1;
        IRin       = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T4;
        if (is_3op) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_2op) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_unary) begin
          Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1;
        end else if (is_halt) begin
          Done       = 1'b1;
          next_state = S_HALT;
        end else begin
          next_state = S_HALT;
        end
      end
      // IR is held stable through execute, so T4-T6 reuse the T3 decode.
      S_T4: begin
        next_state = S_T5;
        if (is_3op) begin
          Grc = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1;
        end else if (is_2op) begin
          Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1;
        end else if (is_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
          next_state = DONE_NEXT;
        end else begin
          next_state = S_HALT;
        end
      end
      S_T5: begin
        if (is_3op) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
          next_state = DONE_NEXT;
        end else if (is_2op) begin
          Zlowout    = 1'b1;
          LOin       = 1'b1;
          next_state = S_T6;
        end else begin
          next_state = S_HALT;
        end
      end
      S_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        Done       = 1'b1;
        next_state = DONE_NEXT;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  assign alu_op    = alu_en ? 5'(opcode) : 5'd0;
  assign Illegal   = illegal_q;
  assign dbg_state = state;

endmodule
